mem_port_arbiter: RTL and testbench

- Parametrised successor of the two-channel shared-word-memory distributor.
- Arbitrates CHANNELS producer/consumer units onto one shared dual-port word memory, which has one write port and one read port with fixed read latency.
- Round-robin grant with ownership held while the owner's busy stays high.
- Registered forwarding of the owner's write/read commands, and tagged read-return routing so read data always reaches the issuing channel, even after ownership changes.

---
 rtl/mem_port_arbiter.sv | 141 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one dual-port word memory among CHANNELS units.
// Owner commands are forwarded registered; read returns are routed by issuer tag.
module mem_port_arbiter #(
  parameter int CHANNELS = 4,
  parameter int DATA_W   = 12,
  parameter int ADDR_W   = 10,
  parameter int RD_LAT   = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [CHANNELS-1:0]          busy,
  output logic [CHANNELS-1:0]          grant,
  input  logic [CHANNELS*DATA_W-1:0]   wr_data,
  input  logic [CHANNELS*ADDR_W-1:0]   wr_addr,
  input  logic [CHANNELS-1:0]          wr_en,
  input  logic [CHANNELS*ADDR_W-1:0]   rd_addr,
  input  logic [CHANNELS-1:0]          rd_en,
  output logic [CHANNELS*DATA_W-1:0]   rd_data,
  output logic [CHANNELS-1:0]          rd_valid,
  output logic [DATA_W-1:0]            comm_wr_data,
  output logic [ADDR_W-1:0]            comm_wr_addr,
  output logic                         comm_wren,
  output logic [ADDR_W-1:0]            comm_rd_addr,
  output logic                         comm_rd_en,
  input  logic [DATA_W-1:0]            comm_rd_data
);

  localparam int OW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_OWNED   = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

  logic [1:0]        state_r;
  logic [OW-1:0]     owner_r;
  logic [OW-1:0]     ptr_r;
  logic              found_s;
  logic [OW-1:0]     winner_s;
  logic [OW-1:0]     next_ptr_s;
  logic              fwd_s;
  logic [RD_LAT-1:0] tag_vld_r;
  logic [OW-1:0]     tag_r [RD_LAT];

  // Scanning downward lets the lowest offset from start win: {found, index}.
  function automatic logic [OW:0] pick_first(input logic [CHANNELS-1:0] req,
                                             input logic [OW-1:0] start);
    logic [OW:0] res;
    int          idx;
    res = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      idx = (int'(start) + i) % CHANNELS;
      if (req[OW'(idx)]) res = {1'b1, OW'(idx)};
      else               res = res;
    end
    return res;
  endfunction

  // Round-robin winner lookup and forwarding qualifier
  always_comb begin
    {found_s, winner_s} = pick_first(busy, ptr_r);
    next_ptr_s          = OW'((int'(winner_s) + 1) % CHANNELS);
    fwd_s               = (state_r == ST_OWNED) && busy[owner_r];
  end

  // Ownership state machine; RELEASE is the dead cycle and arbitrates on its exit edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      owner_r <= '0;
      ptr_r   <= '0;
      grant   <= '0;
    end else begin
      case (state_r)
        ST_IDLE, ST_RELEASE: begin
          if (found_s) begin
            state_r <= ST_OWNED;
            owner_r <= winner_s;
            ptr_r   <= next_ptr_s;
            grant   <= CHANNELS'(1) << winner_s;
          end else begin
            state_r <= ST_IDLE;
            grant   <= '0;
          end
        end
        ST_OWNED: begin
          if (!busy[owner_r]) begin
            state_r <= ST_RELEASE;
            grant   <= '0;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          grant   <= '0;
        end
      endcase
    end
  end

  // Registered command forwarding; address/data hold when not forwarding
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      comm_wr_data <= '0;
      comm_wr_addr <= '0;
      comm_wren    <= 1'b0;
      comm_rd_addr <= '0;
      comm_rd_en   <= 1'b0;
    end else if (fwd_s) begin
      comm_wr_data <= wr_data[owner_r*DATA_W +: DATA_W];
      comm_wr_addr <= wr_addr[owner_r*ADDR_W +: ADDR_W];
      comm_wren    <= wr_en[owner_r];
      comm_rd_addr <= rd_addr[owner_r*ADDR_W +: ADDR_W];
      comm_rd_en   <= rd_en[owner_r];
    end else begin
      comm_wren    <= 1'b0;
      comm_rd_en   <= 1'b0;
    end
  end

  // Issuer tag pipeline aligned with memory read latency, and return routing
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_vld_r <= '0;
      for (int k = 0; k < RD_LAT; k++) tag_r[k] <= '0;
      rd_valid  <= '0;
      rd_data   <= '0;
    end else begin
      tag_vld_r[0] <= fwd_s & rd_en[owner_r];
      tag_r[0]     <= owner_r;
      for (int k = 1; k < RD_LAT; k++) begin
        tag_vld_r[k] <= tag_vld_r[k-1];
        tag_r[k]     <= tag_r[k-1];
      end
      rd_valid <= '0;
      if (tag_vld_r[RD_LAT-1]) begin
        rd_valid[tag_r[RD_LAT-1]]                    <= 1'b1;
        rd_data[tag_r[RD_LAT-1]*DATA_W +: DATA_W]    <= comm_rd_data;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table, hand-written corner sequences and a
// read-return scoreboard fed by a simple fixed-latency memory model.
module tb_mem_port_arbiter;
  localparam int CH  = 4;
  localparam int DW  = 12;
  localparam int AW  = 10;
  localparam int LAT = 2;
  localparam int NV  = 9;

  logic              clk = 1'b0;
  logic              reset;
  logic [CH-1:0]     busy, grant, wr_en, rd_en, rd_valid;
  logic [CH*DW-1:0]  wr_data, rd_data;
  logic [CH*AW-1:0]  wr_addr, rd_addr;
  logic [DW-1:0]     comm_wr_data, comm_rd_data;
  logic [AW-1:0]     comm_wr_addr, comm_rd_addr;
  logic              comm_wren, comm_rd_en;

  typedef struct packed {
    logic [CH-1:0] busy;
    logic [CH-1:0] wr_en;
    logic [CH-1:0] rd_en;
    logic [CH-1:0] grant;
    logic          wren;
    logic          rden;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic [AW-1:0] raddr;
  } vec_t;

  typedef struct packed {
    logic [3:0]    ch;
    logic [DW-1:0] data;
  } rd_exp_t;

  vec_t     tbl [NV];
  rd_exp_t  exp_q [$];
  rd_exp_t  mon_e;
  int       pass_cnt = 0;
  int       total_cnt = 0;
  logic [CH-1:0] prev_g;
  logic [AW-1:0] mem_addr_d;

  mem_port_arbiter #(.CHANNELS(CH), .DATA_W(DW), .ADDR_W(AW), .RD_LAT(LAT)) dut (
    .clk(clk), .reset(reset), .busy(busy), .grant(grant),
    .wr_data(wr_data), .wr_addr(wr_addr), .wr_en(wr_en),
    .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
    .comm_wr_data(comm_wr_data), .comm_wr_addr(comm_wr_addr), .comm_wren(comm_wren),
    .comm_rd_addr(comm_rd_addr), .comm_rd_en(comm_rd_en), .comm_rd_data(comm_rd_data)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return {2'b00, a} + 12'h100;
  endfunction

  // Memory with data valid LAT cycles after the read command is registered
  always @(posedge clk) mem_addr_d <= comm_rd_addr;
  assign comm_rd_data = mem_word(mem_addr_d);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int n = 0; n < 10 && exp_q.size() != 0; n++) tick;
    chk(name, exp_q.size(), 0);
  endtask

  function automatic vec_t mk(input logic [3:0] b, input logic [3:0] w, input logic [3:0] r,
                              input logic [3:0] g, input logic we, input logic re,
                              input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                              input logic [AW-1:0] ra);
    vec_t v;
    v = {b, w, r, g, we, re, wa, wd, ra};
    return v;
  endfunction

  // Scoreboard: every rd_valid pulse must match the oldest outstanding read
  always @(negedge clk) begin
    if (!reset && rd_valid != 4'b0000) begin
      if (exp_q.size() == 0) begin
        chk("rd_unexpected", rd_valid, 4'b0000);
      end else begin
        mon_e = exp_q.pop_front();
        chk("sb_rd_valid", rd_valid, 4'b0001 << mon_e.ch);
        chk("sb_rd_data", rd_data[mon_e.ch*DW +: DW], mon_e.data);
      end
    end
  end

  initial begin
    // busy, wr_en, rd_en -> grant, wren, rden, waddr, wdata, raddr
    tbl[0] = mk(4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b0, 1'b0, 10'h000, 12'h000, 10'h000);
    tbl[1] = mk(4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b1, 1'b0, 10'h005, 12'hABC, 10'h000);
    tbl[2] = mk(4'b0001, 4'b0100, 4'b0100, 4'b0001, 1'b0, 1'b0, 10'h000, 12'h000, 10'h000);
    tbl[3] = mk(4'b0101, 4'b0000, 4'b0001, 4'b0001, 1'b0, 1'b1, 10'h000, 12'h000, 10'h020);
    tbl[4] = mk(4'b0100, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 10'h000, 12'h000, 10'h000);
    tbl[5] = mk(4'b0100, 4'b0000, 4'b0000, 4'b0100, 1'b0, 1'b0, 10'h000, 12'h000, 10'h000);
    tbl[6] = mk(4'b0100, 4'b0100, 4'b0100, 4'b0100, 1'b1, 1'b1, 10'h025, 12'hABE, 10'h022);
    tbl[7] = mk(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 10'h000, 12'h000, 10'h000);
    tbl[8] = mk(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 10'h000, 12'h000, 10'h000);

    reset = 1'b0; busy = '0; wr_en = '0; rd_en = '0;
    for (int c = 0; c < CH; c++) begin
      wr_addr[c*AW +: AW] = 10'h005 + AW'(16 * c);
      wr_data[c*DW +: DW] = 12'hABC + DW'(c);
      rd_addr[c*AW +: AW] = 10'h020 + AW'(c);
    end
    #1 reset = 1'b1;
    #2;
    chk("rst_grant", grant, 4'b0000);
    chk("rst_rd_valid", rd_valid, 4'b0000);
    chk("rst_rd_data", rd_data, 48'h0);
    chk("rst_comm", {comm_wren, comm_rd_en, comm_wr_addr, comm_rd_addr, comm_wr_data}, 64'h0);
    do_reset;

    // Table: single owner write, non-owner ignored, release gap, write+read together
    prev_g = '0;
    for (int i = 0; i < NV; i++) begin
      busy = tbl[i].busy; wr_en = tbl[i].wr_en; rd_en = tbl[i].rd_en;
      for (int c = 0; c < CH; c++)
        if (rd_en[c] && busy[c] && prev_g[c])
          exp_q.push_back({4'(c), mem_word(rd_addr[c*AW +: AW])});
      tick;
      chk($sformatf("tbl%0d_grant", i), grant, tbl[i].grant);
      chk($sformatf("tbl%0d_wren", i), comm_wren, tbl[i].wren);
      chk($sformatf("tbl%0d_rden", i), comm_rd_en, tbl[i].rden);
      if (tbl[i].wren) begin
        chk($sformatf("tbl%0d_waddr", i), comm_wr_addr, tbl[i].waddr);
        chk($sformatf("tbl%0d_wdata", i), comm_wr_data, tbl[i].wdata);
      end
      if (tbl[i].rden) chk($sformatf("tbl%0d_raddr", i), comm_rd_addr, tbl[i].raddr);
      prev_g = tbl[i].grant;
    end
    wr_en = '0; rd_en = '0;
    drain("tbl_drain");

    // Round-robin with all channels busy, each owner leaving after 3 cycles
    do_reset;
    busy = 4'b1111;
    tick;
    for (int o = 0; o < CH; o++) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("rr%0d_own%0d", o, k), grant, 4'b0001 << o);
        if (k < 2) tick;
      end
      busy = 4'b1111 & ~(4'b0001 << o);
      tick;
      chk($sformatf("rr%0d_gap", o), grant, 4'b0000);
      busy = 4'b1111;
      tick;
    end
    chk("rr_wrap", grant, 4'b0001);

    // Tagged return: channel 1 reads on its last owned cycle, channel 3 takes over
    do_reset;
    busy = 4'b1010;
    tick;
    chk("tag_grant1", grant, 4'b0010);
    rd_addr[1*AW +: AW] = 10'h023; rd_en = 4'b0010;
    exp_q.push_back({4'd1, mem_word(10'h023)});
    tick;
    chk("tag_comm_rd_en", comm_rd_en, 1'b1);
    rd_en = 4'b0000; busy = 4'b1000;
    tick;
    chk("tag_early", rd_valid, 4'b0000);
    chk("tag_gap", grant, 4'b0000);
    tick;
    chk("tag_valid", rd_valid, 4'b0010);
    chk("tag_data1", rd_data[1*DW +: DW], 12'h123);
    chk("tag_data3", rd_data[3*DW +: DW], 12'h000);
    chk("tag_grant3", grant, 4'b1000);

    // Back-to-back reads from channel 3, addresses 0..3
    for (int a = 0; a < 4; a++) begin
      rd_addr[3*AW +: AW] = AW'(a); rd_en = 4'b1000;
      exp_q.push_back({4'd3, mem_word(AW'(a))});
      tick;
      if (a >= 2) begin
        chk($sformatf("b2b_valid%0d", a - 2), rd_valid, 4'b1000);
        chk($sformatf("b2b_data%0d", a - 2), rd_data[3*DW +: DW], 12'h100 + DW'(a - 2));
      end
    end
    rd_en = 4'b0000;
    for (int b = 2; b < 4; b++) begin
      tick;
      chk($sformatf("b2b_valid%0d", b), rd_valid, 4'b1000);
      chk($sformatf("b2b_data%0d", b), rd_data[3*DW +: DW], 12'h100 + DW'(b));
    end
    tick;
    chk("b2b_end", rd_valid, 4'b0000);
    drain("b2b_drain");

    // Reset with two reads in flight while channel 2 owns
    do_reset;
    busy = 4'b0100;
    tick;
    chk("mid_grant", grant, 4'b0100);
    rd_en = 4'b0100;
    rd_addr[2*AW +: AW] = 10'h030; exp_q.push_back({4'd2, mem_word(10'h030)});
    tick;
    rd_addr[2*AW +: AW] = 10'h031; exp_q.push_back({4'd2, mem_word(10'h031)});
    tick;
    rd_en = 4'b0000;
    reset = 1'b1;
    exp_q.delete();
    #1;
    chk("mid_rst_grant", grant, 4'b0000);
    chk("mid_rst_rd_valid", rd_valid, 4'b0000);
    chk("mid_rst_rd_data", rd_data, 48'h0);
    chk("mid_rst_comm", {comm_wren, comm_rd_en, comm_wr_addr, comm_rd_addr, comm_wr_data}, 64'h0);
    busy = 4'b0110;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    tick;
    chk("mid_first_grant", grant, 4'b0010);
    for (int n = 0; n < 3; n++) begin
      tick;
      chk($sformatf("mid_no_stale%0d", n), rd_valid, 4'b0000);
    end
    chk("final_queue", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
